// File: rtl/module_display_7seg_scan.sv
// Time-multiplexed N-digit common-anode 7-segment scanner.
// Loads are staged in a pending register and committed to the active register at frame wrap.
module module_display_7seg_scan #(
    parameter int N_DIGITS    = 8,
    parameter int REFRESH_CNT = 100000,
    parameter int GUARD       = 16,
    parameter int BLANK_LZ    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] data,
    input  logic [N_DIGITS-1:0]   dp,
    input  logic                  load,
    input  logic                  blank_en,
    output logic [N_DIGITS-1:0]   enable,
    output logic [7:0]            segments,
    output logic                  frame
);

    localparam int PW = $clog2(REFRESH_CNT);
    localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [PW-1:0]         p_q, p_d;
    logic [DW-1:0]         d_q, d_d;
    logic [4*N_DIGITS-1:0] pend_data_q, pend_data_d, act_data_q, act_data_d;
    logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic [N_DIGITS-1:0]   enable_q, enable_d;
    logic [7:0]            seg_q, seg_d;
    logic                  frame_q, frame_d;
    logic                  tick, commit, guard_done;
    logic [N_DIGITS-1:0]   blank;
    logic                  zero_run;
    logic [3:0]            nib_sel;
    logic                  dp_sel, blank_sel;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        tick        = (p_q == PW'(REFRESH_CNT - 1));
        commit      = tick && (d_q == DW'(N_DIGITS - 1));
        p_d         = tick ? '0 : p_q + 1'b1;
        d_d         = d_q;
        if (tick) begin
            d_d = commit ? '0 : d_q + 1'b1;
        end
        frame_d     = commit;
        // The commit uses the pending value from before this edge, so a coinciding load lands next frame.
        pend_data_d = load ? data : pend_data_q;
        pend_dp_d   = load ? dp : pend_dp_q;
        act_data_d  = commit ? pend_data_q : act_data_q;
        act_dp_d    = commit ? pend_dp_q : act_dp_q;
    end

    // Blank digit i when it and every more-significant nibble are zero; digit 0 always shows.
    always_comb begin
        blank    = '0;
        zero_run = 1'b1;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            zero_run = zero_run && (act_data_q[4*(N_DIGITS-1-k) +: 4] == 4'h0);
            blank[N_DIGITS-1-k] = zero_run && (k != N_DIGITS - 1) &&
                                  (BLANK_LZ != 0) && blank_en;
        end
    end

    always_comb begin
        guard_done = (int'(p_q) >= GUARD);
        nib_sel    = '0;
        dp_sel     = 1'b0;
        blank_sel  = 1'b0;
        enable_d   = '1;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (d_q == DW'(i)) begin
                nib_sel     = act_data_q[4*i +: 4];
                dp_sel      = act_dp_q[i];
                blank_sel   = blank[i];
                enable_d[i] = !guard_done;
            end
        end
        seg_d = {~dp_sel, blank_sel ? 7'h7F : hex_decode(nib_sel)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q         <= '0;
            d_q         <= '0;
            pend_data_q <= '0;
            pend_dp_q   <= '0;
            act_data_q  <= '0;
            act_dp_q    <= '0;
            enable_q    <= '1;
            seg_q       <= 8'hFF;
            frame_q     <= 1'b0;
        end else begin
            p_q         <= p_d;
            d_q         <= d_d;
            pend_data_q <= pend_data_d;
            pend_dp_q   <= pend_dp_d;
            act_data_q  <= act_data_d;
            act_dp_q    <= act_dp_d;
            enable_q    <= enable_d;
            seg_q       <= seg_d;
            frame_q     <= frame_d;
        end
    end

    assign enable   = enable_q;
    assign segments = seg_q;
    assign frame    = frame_q;

endmodule

// File: tb/tb_module_display_7seg_scan.sv
// Scoreboard bench for the 4-digit scanner: expected per-slot segments are queued at load time
// and checked as each digit slot appears on the anodes.
module tb_module_display_7seg_scan;

    localparam int N = 4;
    localparam int R = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [4*N-1:0] data = '0;
    logic [N-1:0]   dp = '0;
    logic           load = 1'b0;
    logic           blank_en = 1'b0;
    logic [N-1:0]   enable;
    logic [7:0]     segments;
    logic           frame;

    int tests = 0;
    int failed = 0;

    typedef struct {
        bit         wf;
        int         dig;
        logic [7:0] seg;
    } exp_t;
    exp_t q[$];

    logic [6:0] dec_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    module_display_7seg_scan #(
        .N_DIGITS(N), .REFRESH_CNT(R), .GUARD(1), .BLANK_LZ(1)
    ) dut (
        .clk(clk), .rst(rst), .data(data), .dp(dp), .load(load), .blank_en(blank_en),
        .enable(enable), .segments(segments), .frame(frame)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) check("one_enable_low", 32'($countones(~enable) <= 1), 32'd1);

    function automatic logic [7:0] model_seg(input logic [4*N-1:0] dv, input logic [N-1:0] dpv,
                                             input bit blank, input int i);
        logic [4*N-1:0] upper;
        logic [3:0]     nib;
        upper = dv >> (4 * i);
        nib   = upper[3:0];
        if (blank && i != 0 && upper == '0) return {~dpv[i], 7'h7F};
        return {~dpv[i], dec_tbl[nib]};
    endfunction

    task automatic load_word(input logic [4*N-1:0] dv, input logic [N-1:0] dpv);
        data = dv;
        dp   = dpv;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic push_frame(input logic [4*N-1:0] dv, input logic [N-1:0] dpv, input bit blank);
        for (int i = 0; i < N; i++) q.push_back('{i == 0, i, model_seg(dv, dpv, blank, i)});
    endtask

    task automatic wait_slot(input int dig, output bit found);
        logic [N-1:0] want;
        want  = ~(N'(1) << dig);
        found = 1'b0;
        for (int k = 0; k < 5 * N * R; k++) begin
            @(negedge clk);
            if (enable == want) begin
                found = 1'b1;
                break;
            end
        end
        check($sformatf("slot_d%0d_seen", dig), 32'(found), 32'd1);
    endtask

    task automatic wait_frame();
        bit found;
        found = 1'b0;
        for (int k = 0; k < 2 * N * R + 4; k++) begin
            @(negedge clk);
            if (frame) begin
                found = 1'b1;
                break;
            end
        end
        check("frame_seen", 32'(found), 32'd1);
        if (found) begin
            @(negedge clk);
            check("frame_width", 32'(frame), 32'd0);
        end
    endtask

    task automatic drain();
        exp_t e;
        bit   found;
        while (q.size() > 0) begin
            e = q.pop_front();
            if (e.wf) wait_frame();
            wait_slot(e.dig, found);
            if (found) check($sformatf("seg_d%0d", e.dig), 32'(segments), 32'(e.seg));
        end
    endtask

    logic [N-1:0] rel_seq [6] = '{4'b1111, 4'b1110, 4'b1110, 4'b1110, 4'b1111, 4'b1101};

    initial begin
        bit found;
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_enable", 32'(enable), 32'hF);
        check("rst_segments", 32'(segments), 32'hFF);
        check("rst_frame", 32'(frame), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("release_c%0d", c + 1), 32'(enable), 32'(rel_seq[c]));
        end

        // First frame: 1234, full scan order then wrap to digit 0
        load_word(16'h1234, 4'h0);
        push_frame(16'h1234, 4'h0, 1'b0);
        q.push_back('{1'b0, 0, 8'h99});
        drain();

        // Load mid-frame: old data stays visible until the wrap
        wait_slot(1, found);
        load_word(16'hABCD, 4'h0);
        q.push_back('{1'b0, 2, 8'hA4});
        q.push_back('{1'b0, 3, 8'hF9});
        q.push_back('{1'b1, 0, 8'hA1});
        q.push_back('{1'b0, 3, 8'h88});
        drain();

        // Leading-zero blanking
        blank_en = 1'b1;
        load_word(16'h0050, 4'h0);
        push_frame(16'h0050, 4'h0, 1'b1);
        drain();
        load_word(16'h0000, 4'h0);
        push_frame(16'h0000, 4'h0, 1'b1);
        drain();

        // blank_en is live: dropping it un-blanks without a new frame
        wait_slot(0, found);
        blank_en = 1'b0;
        q.push_back('{1'b0, 3, 8'hC0});
        q.push_back('{1'b0, 1, 8'hC0});
        drain();

        // Decimal point on digit 2
        wait_slot(3, found);
        blank_en = 1'b1;
        load_word(16'h8888, 4'b0100);
        push_frame(16'h8888, 4'b0100, 1'b1);
        drain();

        // Asynchronous reset mid-scan
        wait_slot(2, found);
        #1 rst = 1'b1;
        #1;
        check("midrst_enable", 32'(enable), 32'hF);
        check("midrst_segments", 32'(segments), 32'hFF);
        check("midrst_frame", 32'(frame), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (enable != 4'hF) begin
                found = 1'b1;
                break;
            end
        end
        check("midrst_first_slot", 32'(enable), 32'(4'b1110));
        check("midrst_seg_d0", 32'(segments), 32'hC0);
        q.push_back('{1'b0, 1, 8'hFF});
        q.push_back('{1'b0, 3, 8'hFF});
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
